// File: rtl/preem_frame_reader.sv
// preem_frame_reader: streams overlapping frames of pre-emphasised samples out of a circular memory.
module preem_frame_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [LEN_WIDTH-1:0]  frame_shift,
    input  logic                  base_clr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] out_frame_num,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] base, rd_ptr, frame_num;
    logic [LEN_WIDTH-1:0]  len_q, shift_q, issued, dcnt;
    logic [DATA_WIDTH-1:0] s0, s1, v0, v1;
    logic [1:0]            cnt, occ;
    logic                  inflight, issue, pop;
    // The word returning from memory is visible at the head in its arrival cycle, so the
    // two stored entries plus the in-flight read form a single ordered queue.
    assign occ           = cnt + {1'b0, inflight};
    assign issue         = state == READ && issued < len_q && occ < 2'd2;
    assign out_valid     = occ != 2'd0;
    assign out_data      = cnt != 2'd0 ? s0 : (inflight ? mem_rd_data : '0);
    assign out_last      = out_valid && dcnt == len_q - LEN_WIDTH'(1);
    assign pop           = out_valid & out_ready;
    assign v0            = cnt != 2'd0 ? s0 : mem_rd_data;
    assign v1            = cnt == 2'd2 ? s1 : mem_rd_data;
    assign mem_rd_en     = issue;
    assign mem_rd_addr   = issue ? rd_ptr : '0;
    assign busy          = state == READ || state == DRAIN;
    assign done          = state == DONE;
    assign out_frame_num = frame_num;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = frame_start ? (frame_len != '0 ? READ : DONE) : IDLE;
            READ:    state_n = issue && issued == len_q - LEN_WIDTH'(1) ? DRAIN : READ;
            DRAIN:   state_n = pop && out_last ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            rd_ptr    <= '0;
            frame_num <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            issued    <= '0;
            dcnt      <= '0;
            s0        <= '0;
            s1        <= '0;
            cnt       <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            cnt      <= occ - {1'b0, pop};
            s0       <= pop ? v1 : v0;
            s1       <= pop ? mem_rd_data : v1;
            dcnt     <= state == IDLE ? '0 : (pop ? dcnt + LEN_WIDTH'(1) : dcnt);
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                issued <= issued + LEN_WIDTH'(1);
            end
            if (state == IDLE) begin
                if (base_clr) begin
                    base      <= '0;
                    frame_num <= '0;
                end
                if (frame_start) begin
                    len_q   <= frame_len;
                    shift_q <= frame_shift;
                    rd_ptr  <= base_clr ? '0 : base;
                    issued  <= '0;
                end
            end
            if (state == DONE && len_q != '0) begin
                base      <= base + ADDR_WIDTH'(shift_q);
                frame_num <= frame_num + ADDR_WIDTH'(1);
            end
        end
    end
endmodule
